// File: rtl/run_event_monitor.sv
// run_event_monitor: windowed z rising-edge count and longest run with valid/ready result; define RUN_MON_CONT_EN for continuous windows
module run_event_monitor #(
  parameter int WINDOW = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             z,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] evt_count,
  output logic [CNT_W-1:0] max_run,
  output logic             ovf,
  output logic             res_valid,
  input  logic             res_ready
);
  localparam int WC_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] MAXV = '1;
  localparam logic [WC_W-1:0] LAST = WC_W'(WINDOW - 1);
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  state_t state;
  logic z_d, go, run_sat, evt_inc, evt_sat;
  logic [CNT_W-1:0] run, run_next;
  logic [WC_W-1:0] wcnt;
  always_comb begin
    run_sat = z && run == MAXV;
    run_next = z ? (run_sat ? run : run + 1'b1) : '0;
    evt_inc = z && !z_d;
    evt_sat = evt_inc && evt_count == MAXV;
  end
`ifdef RUN_MON_CONT_EN
  assign go = state == IDLE ? start : state == HOLD && res_ready;
`else
  assign go = state == IDLE && start;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      res_valid <= 1'b0;
      evt_count <= '0;
      max_run <= '0;
      ovf <= 1'b0;
      run <= '0;
      wcnt <= '0;
      z_d <= 1'b0;
    end else if (go) begin
      state <= COUNT;
      busy <= 1'b1;
      res_valid <= 1'b0;
      evt_count <= '0;
      max_run <= '0;
      ovf <= 1'b0;
      run <= '0;
      wcnt <= '0;
      z_d <= 1'b0;
    end else if (state == COUNT) begin
      z_d <= z;
      run <= run_next;
      wcnt <= wcnt + 1'b1;
      if (evt_inc && !evt_sat) evt_count <= evt_count + 1'b1;
      if (run_next > max_run) max_run <= run_next;
      if (run_sat || evt_sat) ovf <= 1'b1;
      if (wcnt == LAST) begin
        state <= HOLD;
        busy <= 1'b0;
        res_valid <= 1'b1;
      end
    end else if (state == HOLD && res_ready) begin
      state <= IDLE;
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_run_event_monitor.sv
// tb_run_event_monitor: randomized and directed checks of run_event_monitor against a run-list reference model
module tb_run_event_monitor;
  typedef bit bq_t[$];
  localparam int MAXV = 255;
  logic clk = 1'b0;
  logic rst_n, z, start, start2, res_ready;
  logic busy, ovf, res_valid, s_busy, s_ovf, s_valid;
  logic [7:0] evt_count, max_run, s_evt, s_max;
  int total = 0;
  int bad = 0;
  int e_evt, e_mr;
  bit e_ov;
  bq_t q;
  always #5 clk = ~clk;
  run_event_monitor #(.WINDOW(16), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .z(z), .start(start), .busy(busy), .evt_count(evt_count),
    .max_run(max_run), .ovf(ovf), .res_valid(res_valid), .res_ready(res_ready)
  );
  run_event_monitor #(.WINDOW(300), .CNT_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .z(z), .start(start2), .busy(s_busy), .evt_count(s_evt),
    .max_run(s_max), .ovf(s_ovf), .res_valid(s_valid), .res_ready(res_ready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic bq_t pat_q(input logic [15:0] p);
    bq_t r;
    for (int i = 15; i >= 0; i--) r.push_back(p[i]);
    return r;
  endfunction
  function automatic void ref_model(input bq_t s, output int e, output int m, output bit o);
    int runs[$];
    int len = 0;
    foreach (s[i]) begin
      if (s[i]) len++;
      else if (len > 0) begin
        runs.push_back(len);
        len = 0;
      end
    end
    if (len > 0) runs.push_back(len);
    m = 0;
    foreach (runs[i]) if (runs[i] > m) m = runs[i];
    e = runs.size();
    o = e > MAXV || m > MAXV;
    if (e > MAXV) e = MAXV;
    if (m > MAXV) m = MAXV;
  endfunction
  task automatic drive_win(input bq_t s, input bit sat);
    @(negedge clk);
    if (sat) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
    chk("busy_count", sat ? s_busy : busy, 1);
    foreach (s[i]) begin
      z = s[i];
      @(negedge clk);
    end
    z = 1'b0;
  endtask
  task automatic chk_res(input string tag, input int ee, input int em, input bit eo);
    chk({tag, ".valid"}, res_valid, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".evt"}, evt_count, ee);
    chk({tag, ".max"}, max_run, em);
    chk({tag, ".ovf"}, ovf, eo);
  endtask
  task automatic handshake(input int ee, input int em, input bit eo);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("hs.valid", res_valid, 0);
`ifdef RUN_MON_CONT_EN
    chk("hs.busy", busy, 1);
`else
    chk("hs.busy", busy, 0);
    chk("hs.evt_held", evt_count, ee);
    chk("hs.max_held", max_run, em);
    chk("hs.ovf_held", ovf, eo);
    repeat (3) @(negedge clk);
    chk("idle.valid", res_valid, 0);
    chk("idle.busy", busy, 0);
`endif
  endtask
  initial begin
    rst_n = 1'b0;
    z = 1'b1;
    start = 1'b1;
    start2 = 1'b1;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.valid", res_valid, 0);
    chk("rst.evt", evt_count, 0);
    chk("rst.max", max_run, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.sat_valid", s_valid, 0);
    rst_n = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    z = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst.quiet", {res_valid, busy}, 0);
    end
    drive_win(pat_q(16'b0011100011110000), 1'b0);
    chk_res("basic", 2, 4, 1'b0);
    handshake(2, 4, 1'b0);
`ifdef RUN_MON_CONT_EN
    q = pat_q(16'(($urandom)));
    ref_model(q, e_evt, e_mr, e_ov);
    foreach (q[i]) begin
      z = q[i];
      @(negedge clk);
    end
    z = 1'b0;
    chk_res("cont", e_evt, e_mr, e_ov);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("cont.rst_valid", res_valid, 0);
`else
    drive_win(pat_q(16'hffff), 1'b0);
    chk_res("all_ones", 1, 16, 1'b0);
    handshake(1, 16, 1'b0);
    drive_win(pat_q(16'b1000000000000001), 1'b0);
    chk_res("ends", 2, 1, 1'b0);
    handshake(2, 1, 1'b0);
    q = pat_q(16'(($urandom)));
    ref_model(q, e_evt, e_mr, e_ov);
    drive_win(q, 1'b0);
    chk_res("bp", e_evt, e_mr, e_ov);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      @(negedge clk);
      chk_res("bp.hold", e_evt, e_mr, e_ov);
    end
    start = 1'b0;
    handshake(e_evt, e_mr, e_ov);
    for (int k = 0; k < 4; k++) begin
      q = pat_q(16'(($urandom)));
      ref_model(q, e_evt, e_mr, e_ov);
      drive_win(q, 1'b0);
      chk_res("rand", e_evt, e_mr, e_ov);
      handshake(e_evt, e_mr, e_ov);
    end
`endif
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      z = 1'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.busy", busy, 0);
    chk("midrst.valid", res_valid, 0);
    chk("midrst.evt", evt_count, 0);
    chk("midrst.max", max_run, 0);
    chk("midrst.ovf", ovf, 0);
    rst_n = 1'b1;
    z = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("midrst.quiet", {res_valid, busy}, 0);
    end
    q = {};
    for (int i = 0; i < 300; i++) q.push_back(1'b1);
    ref_model(q, e_evt, e_mr, e_ov);
    drive_win(q, 1'b1);
    chk("sat.valid", s_valid, 1);
    chk("sat.evt", s_evt, e_evt);
    chk("sat.max", s_max, e_mr);
    chk("sat.ovf", s_ovf, e_ov);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("sat.hs_valid", s_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
